// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO-front arbiters.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: ARB_MAX_REQ (largest supported requester count), clog2() for
// deriving index widths, arb_id_t (a source ID wide enough for ARB_MAX_REQ).
package fifo_arb_pkg;

  localparam int ARB_MAX_REQ = 16;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int ARB_ID_MAX_W = clog2(ARB_MAX_REQ);

  // Source ID wide enough for the largest arbiter; instances narrow to their own ID_W.
  typedef logic [ARB_ID_MAX_W-1:0] arb_id_t;

endpackage

// File: rtl/fifo.sv
// Generic valid/ready FIFO, DEPTH entries of WIDTH bits.
// Latency: 1 cycle from push to out_val.
// Backpressure: in_rdy low when full; entries hold while out_rdy is low.
// Ports: clk, rst_n (async active-low), in_val/in_rdy/in_data write side,
//        out_val/out_rdy/out_data read side (out_data valid when out_val).
module fifo
  import fifo_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             push, pop;

  assign in_rdy   = (cnt != FULL);
  assign out_val  = (cnt != '0);
  assign out_data = mem[rptr];
  assign push     = in_val && in_rdy;
  assign pop      = out_val && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
    end
  end

  // Storage needs no reset: cnt gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

endmodule

// File: rtl/rr_prio_pick.sv
// Rotating priority picker: first set bit of req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; callers gate the grant with their own load condition.
// Ports: req (request vector), ptr (highest-priority index, must be < N),
//        gnt (one-hot grant), idx (encoded grant), any (some request present).
module rr_prio_pick
  import fifo_arb_pkg::*;
#(
  parameter int  N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  localparam logic [W:0] NV = (W+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  always_comb begin
    // Rotate so that position 0 is the requester at ptr.
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    // Find-first: scanning downward lets the lowest set bit win last.
    off = '0;
    any = 1'b0;
    for (int o = N - 1; o >= 0; o--) begin
      if (rot[o]) begin
        off = W'(o);
        any = 1'b1;
      end
    end
    // Un-rotate with an explicit modulo-N wrap (N need not be a power of two).
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NV) sum = sum - NV;
    idx = sum[W-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Latency: 1 cycle from accepted handshake to out_val; 1 beat/cycle sustained.
// Backpressure: while out_val && !out_rdy all req_rdy are low and the held beat is frozen.
// Ports: clk, rst_n (async active-low); req_val/req_rdy/req_data per-requester
//        handshakes (requester i owns req_data[i*SIZE +: SIZE]); out_val/out_rdy/
//        out_data/out_id drive the downstream FIFO, out_id naming the source.
// Build option: define FIFO_ARB_BURST_EN to keep a grant locked to one requester
// for up to BURST_LEN consecutive beats.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NREQ      = 4,
  parameter int  SIZE      = 4,
  parameter int  BURST_LEN = 4,
  localparam int ID_W      = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_val,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*SIZE-1:0] req_data,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [SIZE-1:0]      out_data,
  output logic [ID_W-1:0]      out_id
);

  if (NREQ < 2 || NREQ > ARB_MAX_REQ || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_param
    $error("fifo_rr_arbiter: parameter out of range");
  end

  function automatic logic [ID_W-1:0] inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  logic [ID_W-1:0] ptr, ptr_nxt, pick_ptr;
  logic [NREQ-1:0] p_gnt, w_gnt;
  logic [ID_W-1:0] p_idx, w_idx;
  logic            p_any, w_any;
  logic            load, accept;
  logic [SIZE-1:0] sel;

  rr_prio_pick #(.N(NREQ)) u_pick (
    .req (req_val),
    .ptr (pick_ptr),
    .gnt (p_gnt),
    .idx (p_idx),
    .any (p_any)
  );

  assign load   = !out_val || out_rdy;
  assign accept = load && w_any;
  // Gated by rst_n so no requester sees ready while reset is held.
  assign req_rdy = (rst_n && load) ? w_gnt : '0;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) sel = req_data[i*SIZE +: SIZE];
    end
  end

`ifdef FIFO_ARB_BURST_EN
  // bcnt = beats accepted in the current burst; nonzero means the grant is
  // locked to out_id. It returns to 0 as soon as the burst ends, so it never
  // has to hold BURST_LEN itself.
  logic [3:0] bcnt, bcnt_nxt;
  logic [4:0] beats;
  logic       locked, hold;

  assign locked   = (bcnt != 4'd0);
  assign hold     = locked && req_val[out_id];
  // While locked ptr is stale; a released lock resumes scanning after out_id.
  assign pick_ptr = locked ? inc(out_id) : ptr;
  assign w_gnt    = hold ? (NREQ'(1) << out_id) : p_gnt;
  assign w_idx    = hold ? out_id : p_idx;
  assign w_any    = hold || p_any;

  always_comb begin
    ptr_nxt  = ptr;
    bcnt_nxt = bcnt;
    beats    = '0;
    if (accept) begin
      beats = (hold ? {1'b0, bcnt} : 5'd0) + 5'd1;
      if (beats == 5'(BURST_LEN)) begin
        bcnt_nxt = '0;
        ptr_nxt  = inc(w_idx);
      end else begin
        bcnt_nxt = beats[3:0];
      end
    end else if (load && locked) begin
      // Locked requester dropped req_val and nobody else asked.
      bcnt_nxt = '0;
      ptr_nxt  = inc(out_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= '0;
    else        bcnt <= bcnt_nxt;
  end
`else
  assign pick_ptr = ptr;
  assign w_gnt    = p_gnt;
  assign w_idx    = p_idx;
  assign w_any    = p_any;
  assign ptr_nxt  = accept ? inc(w_idx) : ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val  <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
      ptr      <= '0;
    end else begin
      if (accept) begin
        // A new beat replaces one being drained this cycle.
        out_val  <= 1'b1;
        out_data <= sel;
        out_id   <= w_idx;
      end else if (out_rdy) begin
        out_val <= 1'b0;
      end
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Main 4-requester instance.
  logic [3:0]  req_val = '0;
  logic [3:0]  req_rdy;
  logic [15:0] req_data = {4'hD, 4'hC, 4'hB, 4'hA};
  logic        out_val;
  logic        out_rdy = 1'b1;
  logic [3:0]  out_data;
  logic [1:0]  out_id;

  // 3-requester instance.
  logic [2:0]  req_val3 = '0;
  logic [2:0]  req_rdy3;
  logic [11:0] req_data3 = {4'h7, 4'h6, 4'h5};
  logic        out_val3;
  logic        out_rdy3 = 1'b1;
  logic [3:0]  out_data3;
  logic [1:0]  out_id3;

  // Arbiter feeding a 4-deep FIFO.
  logic [3:0]  req_val_f = '0;
  logic [3:0]  req_rdy_f;
  logic        out_val_f, out_rdy_f;
  logic [3:0]  out_data_f;
  logic [1:0]  out_id_f;
  logic        fo_val;
  logic        fo_rdy = 1'b0;
  logic [5:0]  fo_dat;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.NREQ(4), .SIZE(4), .BURST_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy), .req_data(req_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_id(out_id));

  fifo_rr_arbiter #(.NREQ(3), .SIZE(4), .BURST_LEN(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_val(req_val3), .req_rdy(req_rdy3), .req_data(req_data3),
    .out_val(out_val3), .out_rdy(out_rdy3), .out_data(out_data3), .out_id(out_id3));

  fifo_rr_arbiter #(.NREQ(4), .SIZE(4), .BURST_LEN(4)) u_fill (
    .clk(clk), .rst_n(rst_n), .req_val(req_val_f), .req_rdy(req_rdy_f), .req_data(req_data),
    .out_val(out_val_f), .out_rdy(out_rdy_f), .out_data(out_data_f), .out_id(out_id_f));

  fifo #(.DEPTH(4), .WIDTH(6)) u_fifo (
    .clk(clk), .rst_n(rst_n), .in_val(out_val_f), .in_rdy(out_rdy_f), .in_data({out_id_f, out_data_f}),
    .out_val(fo_val), .out_rdy(fo_rdy), .out_data(fo_dat));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    req_val = 4'b1111;
    out_rdy = 1'b1;
    rst_n   = 1'b0;
    repeat (3) tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL rst_out_val got %0h exp 0", out_val); end
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL rst_req_rdy got %b exp 0000", req_rdy); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_out_id got %0d exp 0", out_id); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL rst_out_data got %0h exp 0", out_data); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b exp 0001", req_rdy); end
    tick();
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL rst_first_val got %0h exp 1", out_val); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_first_id got %0d exp 0", out_id); end
    checks++; if (out_data !== 4'hA) begin errors++; $display("FAIL rst_first_data got %0h exp a", out_data); end
  endtask

  task automatic test_rotation;
    logic [1:0] e_id;
    logic [3:0] e_dat;
    req_val = 4'b1111;
    out_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e_id  = 2'(i % 4);
      e_dat = 4'hA + 4'(i % 4);
      checks++; if ($countones(req_rdy) != 1) begin errors++; $display("FAIL rot_onehot[%0d] got %b exp one bit", i, req_rdy); end
      checks++; if (req_rdy !== (4'b0001 << e_id)) begin errors++; $display("FAIL rot_rdy[%0d] got %b exp %b", i, req_rdy, 4'b0001 << e_id); end
      tick();
      checks++; if (out_id !== e_id) begin errors++; $display("FAIL rot_id[%0d] got %0d exp %0d", i, out_id, e_id); end
      checks++; if (out_data !== e_dat) begin errors++; $display("FAIL rot_data[%0d] got %0h exp %0h", i, out_data, e_dat); end
    end
  endtask

  task automatic test_backpressure;
    req_val = 4'b0110;
    out_rdy = 1'b1;
    do_reset();
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL bp_first_rdy got %b exp 0010", req_rdy); end
    tick();
    checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL bp_first_id got %0d exp 1", out_id); end
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL bp_val[%0d] got %0h exp 1", i, out_val); end
      checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL bp_id[%0d] got %0d exp 1", i, out_id); end
      checks++; if (out_data !== 4'hB) begin errors++; $display("FAIL bp_data[%0d] got %0h exp b", i, out_data); end
      checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_rdy[%0d] got %b exp 0000", i, req_rdy); end
      tick();
    end
    out_rdy = 1'b1;
    #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL bp_resume_rdy got %b exp 0100", req_rdy); end
    tick();
    checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL bp_resume_id got %0d exp 2", out_id); end
    checks++; if (out_data !== 4'hC) begin errors++; $display("FAIL bp_resume_data got %0h exp c", out_data); end
    // Reset while a beat is held discards it immediately.
    out_rdy = 1'b0;
    rst_n   = 1'b0;
    #1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL bp_midreset_val got %0h exp 0", out_val); end
    rst_n   = 1'b1;
    out_rdy = 1'b1;
  endtask

  task automatic test_drain_idle;
    req_val = 4'b0001;
    out_rdy = 1'b1;
    do_reset();
    tick();
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL drain_load_val got %0h exp 1", out_val); end
    req_val = 4'b0000;
    #1;
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL drain_idle_rdy got %b exp 0000", req_rdy); end
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL drain_val got %0h exp 0", out_val); end
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL drain_idle_val got %0h exp 0", out_val); end
    req_val = 4'b1111;
    #1;
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL drain_ptr_hold got %b exp 0010", req_rdy); end
    tick();
    checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL drain_next_id got %0d exp 1", out_id); end
    req_val = 4'b0000;
  endtask

  task automatic test_wrap_npot;
    req_val3 = 3'b010;
    do_reset();
    checks++; if (req_rdy3 !== 3'b010) begin errors++; $display("FAIL n3_first_rdy got %b exp 010", req_rdy3); end
    tick();
    checks++; if (out_id3 !== 2'd1 || out_data3 !== 4'h6) begin errors++; $display("FAIL n3_first_beat got id %0d data %0h exp id 1 data 6", out_id3, out_data3); end
    req_val3 = 3'b011;
    #1;
    checks++; if (req_rdy3 !== 3'b001) begin errors++; $display("FAIL n3_wrap_rdy got %b exp 001", req_rdy3); end
    tick();
    checks++; if (out_id3 !== 2'd0 || out_data3 !== 4'h5) begin errors++; $display("FAIL n3_wrap_beat got id %0d data %0h exp id 0 data 5", out_id3, out_data3); end
    checks++; if (req_rdy3 !== 3'b010) begin errors++; $display("FAIL n3_ptr1_rdy got %b exp 010", req_rdy3); end
    tick();
    checks++; if (out_id3 !== 2'd1) begin errors++; $display("FAIL n3_ptr1_id got %0d exp 1", out_id3); end
    req_val3 = 3'b100;
    #1;
    checks++; if (req_rdy3 !== 3'b100) begin errors++; $display("FAIL n3_last_rdy got %b exp 100", req_rdy3); end
    tick();
    checks++; if (out_id3 !== 2'd2 || out_data3 !== 4'h7) begin errors++; $display("FAIL n3_last_beat got id %0d data %0h exp id 2 data 7", out_id3, out_data3); end
    req_val3 = 3'b111;
    #1;
    checks++; if (req_rdy3 !== 3'b001) begin errors++; $display("FAIL n3_ptr_wrap0 got %b exp 001", req_rdy3); end
    tick();
    checks++; if (out_id3 !== 2'd0) begin errors++; $display("FAIL n3_wrap0_id got %0d exp 0", out_id3); end
    req_val3 = 3'b000;
  endtask

  task automatic test_fifo_fill;
    int         acc;
    int         n;
    logic [5:0] e_beat;
    req_val_f = 4'b1111;
    fo_rdy    = 1'b0;
    do_reset();
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      acc += $countones(req_val_f & req_rdy_f);
      tick();
    end
    checks++; if (acc != 5) begin errors++; $display("FAIL fill_accepts got %0d exp 5", acc); end
    checks++; if (out_val_f !== 1'b1) begin errors++; $display("FAIL fill_held got %0h exp 1", out_val_f); end
    req_val_f = 4'b0000;
    fo_rdy    = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (fo_val) begin
        checks++;
        if (n < 5) begin
          e_beat = {2'(n % 4), 4'hA + 4'(n % 4)};
          if (fo_dat !== e_beat) begin errors++; $display("FAIL fill_beat[%0d] got %0h exp %0h", n, fo_dat, e_beat); end
        end else begin
          errors++; $display("FAIL fill_extra_beat[%0d] got %0h exp none", n, fo_dat);
        end
        n++;
      end
      tick();
    end
    checks++; if (n != 5) begin errors++; $display("FAIL fill_drained got %0d exp 5", n); end
    fo_rdy = 1'b0;
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst;
    logic [1:0] exp_seq [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [1:0] e_id;
    req_val = 4'b0011;
    out_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (out_id !== exp_seq[i]) begin errors++; $display("FAIL burst_id[%0d] got %0d exp %0d", i, out_id, exp_seq[i]); end
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      e_id = (i < 4) ? 2'd0 : 2'd1;
      tick();
      checks++; if (out_id !== e_id) begin errors++; $display("FAIL burst_drop_pre[%0d] got %0d exp %0d", i, out_id, e_id); end
    end
    req_val = 4'b0001;
    tick();
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL burst_drop_release got %0d exp 0", out_id); end
    req_val = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_drain_idle();
    test_wrap_npot();
    test_fifo_fill();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
